// File: rtl/mont_pkg.sv
// Shared state encoding, table-entry width and residue-index helper for the
// Montgomery multiplier controller.
package mont_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StBtab   = 3'd1;
  localparam state_t StMtab   = 3'd2;
  localparam state_t StLaunch = 3'd3;
  localparam state_t StWait   = 3'd4;
  localparam state_t StDone   = 3'd5;

  localparam int unsigned DefNbits = 2048;
  localparam int unsigned DefPbits = 1;

  // Table entries hold up to (2^pbits - 1) * operand, so they need pbits of headroom.
  function automatic int unsigned ent_width(input int unsigned nbits, input int unsigned pbits);
    return nbits + pbits;
  endfunction

  // r = (-x) mod 2^pbits, for pbits < 32.
  function automatic int unsigned res_idx(input int unsigned x, input int unsigned pbits);
    return (32'd0 - x) & ((32'd1 << pbits) - 32'd1);
  endfunction

endpackage

// File: rtl/mont_tab_acc.sv
// Table-building accumulator: one adder stepping by b or m, with synchronous clear.
// sum_o is the post-add value so the caller can write it in the same cycle.
module mont_tab_acc
  import mont_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             add_b_i,
  input  logic             add_m_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] m_i,
  output logic [Width-1:0] acc_o,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] acc_q, acc_d;

  assign sum_o = acc_q + (add_m_i ? m_i : b_i);
  assign acc_o = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_b_i || add_m_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mont_mul_ctrl.sv
// Montgomery multiplier sequencer: latches a request, builds the bxn/mxn tables,
// launches the core and returns its result. Optional MONT_TABLE_CACHE_EN reuses tables.
module mont_mul_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned NBITS  = DefNbits,
  parameter int unsigned PBITS  = DefPbits,
  parameter int unsigned MLSIZE = 1 << PBITS,
  localparam int unsigned MSW   = $clog2(NBITS) + 1,
  localparam int unsigned EntW  = ent_width(NBITS, PBITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  input  logic [MSW-1:0]   m_size,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             done_p,
  output logic             err_p,
  output logic             mul_enable_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_m,
  output logic [MSW-1:0]   mul_m_size,
  output logic [EntW-1:0]  mul_bxn [1:MLSIZE-1],
  output logic [EntW-1:0]  mul_mxn [0:MLSIZE-1],
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p
);

  state_t           state_q, state_d;
  logic [PBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] a_q, b_q, m_q, result_q;
  logic [MSW-1:0]   m_size_q;
  logic [EntW-1:0]  bxn_q [1:MLSIZE-1];
  logic [EntW-1:0]  mxn_q [0:MLSIZE-1];
  logic             err_q, done_q;

  logic             accept, cache_hit, last_ent;
  logic             acc_clr, acc_add_b, acc_add_m;
  logic [EntW-1:0]  acc, sum;
  logic [PBITS-1:0] r_idx;

  assign accept   = (state_q == StIdle) && start_p && m[0];
  assign last_ent = (cnt_q == PBITS'(MLSIZE - 1));
  assign r_idx    = PBITS'(res_idx(32'(acc[PBITS-1:0]), PBITS));

`ifdef MONT_TABLE_CACHE_EN
  // b_q/m_q already hold the operands the current tables were built from.
  logic cache_vld_q;
  assign cache_hit = cache_vld_q && (b == b_q) && (m == m_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
    end else if (accept) begin
      cache_vld_q <= cache_hit;
    end else if ((state_q == StMtab) && last_ent) begin
      cache_vld_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  mont_tab_acc #(
    .Width (EntW)
  ) u_tab_acc (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (acc_clr),
    .add_b_i (acc_add_b),
    .add_m_i (acc_add_m),
    .b_i     (EntW'(b_q)),
    .m_i     (EntW'(m_q)),
    .acc_o   (acc),
    .sum_o   (sum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_clr   = 1'b0;
    acc_add_b = 1'b0;
    acc_add_m = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_clr = 1'b1;
          cnt_d   = PBITS'(1);
          state_d = cache_hit ? StLaunch : StBtab;
        end
      end
      StBtab: begin
        acc_add_b = 1'b1;
        if (last_ent) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = StMtab;
        end else begin
          cnt_d = cnt_q + PBITS'(1);
        end
      end
      StMtab: begin
        acc_add_m = 1'b1;
        if (last_ent) begin
          state_d = StLaunch;
        end else begin
          cnt_d = cnt_q + PBITS'(1);
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (mul_done_p) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      m_size_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      bxn_q    <= '{default: '0};
      mxn_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= (state_q == StIdle) && start_p && !m[0];
      done_q  <= (state_q == StDone);
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        m_q      <= m;
        m_size_q <= m_size;
      end
      if (state_q == StBtab) begin
        bxn_q[cnt_q] <= sum;
      end
      // m odd makes r_idx a bijection over k, so each slot is hit exactly once.
      if (state_q == StMtab) begin
        mxn_q[r_idx] <= acc;
      end
      if ((state_q == StWait) && mul_done_p) begin
        result_q <= mul_y;
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign mul_enable_p = (state_q == StLaunch);
  assign done_p       = done_q;
  assign err_p        = err_q;
  assign result       = result_q;
  assign mul_a        = a_q;
  assign mul_m        = m_q;
  assign mul_m_size   = m_size_q;
  assign mul_bxn      = bxn_q;
  assign mul_mxn      = mxn_q;

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Scoreboard bench for mont_mul_ctrl (NBITS=8, PBITS=2) with a table-driven
// radix-4 Montgomery core model; expectations come from plain modular arithmetic.
module tb_mont_mul_ctrl;

  localparam int unsigned NB  = 8;
  localparam int unsigned PB  = 2;
  localparam int unsigned ML  = 4;
  localparam int unsigned EW  = 10;
  localparam int unsigned MSW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start_p;
  logic [NB-1:0] a, b, m;
  logic [MSW-1:0] m_size;
  logic          busy, done_p, err_p, mul_enable_p, mul_done_p;
  logic [NB-1:0] result, mul_a, mul_m, mul_y;
  logic [MSW-1:0] mul_m_size;
  logic [EW-1:0] mul_bxn [1:ML-1];
  logic [EW-1:0] mul_mxn [0:ML-1];
  logic          mdl_done, stray_done;
  logic [NB-1:0] mdl_y;

  assign mul_done_p = mdl_done | stray_done;
  assign mul_y      = mdl_y;

  always #5 clk = ~clk;

  mont_mul_ctrl #(
    .NBITS (NB),
    .PBITS (PB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_p      (start_p),
    .a            (a),
    .b            (b),
    .m            (m),
    .m_size       (m_size),
    .busy         (busy),
    .result       (result),
    .done_p       (done_p),
    .err_p        (err_p),
    .mul_enable_p (mul_enable_p),
    .mul_a        (mul_a),
    .mul_m        (mul_m),
    .mul_m_size   (mul_m_size),
    .mul_bxn      (mul_bxn),
    .mul_mxn      (mul_mxn),
    .mul_y        (mul_y),
    .mul_done_p   (mul_done_p)
  );

  typedef struct {
    bit          is_err;
    int unsigned a, b, m, res, lat;
    int          t;
  } ent_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int unsigned last_m = 0;
  bit          prev_done = 1'b0;
  bit          mul_hold = 1'b0;
`ifdef MONT_TABLE_CACHE_EN
  bit          cv = 1'b0;
  int unsigned cb = 0, cm = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // a*b*2^-8 mod m by search for the unique residue.
  function automatic int unsigned golden(input int unsigned av, bv, mv);
    int unsigned p;
    p = (av * bv) % mv;
    for (int unsigned x = 0; x < mv; x++) if (((x * 256) % mv) == p) return x;
    return 32'hffff_ffff;
  endfunction

  // The multiple of m that cancels residue r modulo 4.
  function automatic int unsigned exp_mxn(input int unsigned mv, r);
    for (int unsigned k = 0; k < ML; k++) if (((k * mv + r) % ML) == 0) return k * mv;
    return 32'hffff_ffff;
  endfunction

  // Multiplier core model: consumes the DUT tables, answers after 3..6 cycles.
  initial begin
    int unsigned s, d, dly;
    mdl_done = 1'b0;
    mdl_y    = '0;
    forever begin
      @(negedge clk);
      if (mul_enable_p && !mul_hold) begin
        s = 0;
        for (int i = 0; i < int'(mul_m_size) / 2; i++) begin
          d = (int'(mul_a) >> (2 * i)) & 3;
          if (d != 0) s = s + mul_bxn[d];
          s = (s + mul_mxn[s & 3]) >> 2;
        end
        if (s >= mul_m) s = s - mul_m;
        dly = $urandom_range(3, 6);
        repeat (dly) @(posedge clk);
        #1;
        mdl_y    = NB'(s);
        mdl_done = 1'b1;
        @(posedge clk);
        #1;
        mdl_done = 1'b0;
      end
    end
  end

  // Monitor: pops and checks the scoreboard on err_p / done_p, checks tables on launch.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cnt    = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          chk("busy_after_done", busy, 0);
          chk("done_one_cycle", done_p, 0);
          prev_done = 1'b0;
        end
        if (err_p) begin
          if (sb.size() == 0) flag("unexpected_err");
          else begin
            e = sb.pop_front();
            chk("err_expected", e.is_err, 1);
            chk("err_latency", cyc + 1 - e.t, 1);
            chk("busy_on_err", busy, 0);
            chk("err_no_latch_m", mul_m, last_m);
            en_cnt = 0;
          end
        end
        if (mul_enable_p) begin
          if (sb.size() == 0) flag("unexpected_enable");
          else begin
            e = sb[0];
            chk("enable_for_err_req", e.is_err, 0);
            chk("enable_count", en_cnt, 0);
            en_cnt++;
            chk("enable_latency", cyc + 1 - e.t, e.lat);
            chk("busy_at_enable", busy, 1);
            chk("mul_a", mul_a, e.a);
            chk("mul_m", mul_m, e.m);
            chk("mul_m_size", mul_m_size, 8);
            for (int j = 1; j < ML; j++) chk($sformatf("bxn%0d", j), mul_bxn[j], j * e.b);
            for (int r = 0; r < ML; r++)
              chk($sformatf("mxn%0d", r), mul_mxn[r], exp_mxn(e.m, r));
          end
        end
        if (done_p) begin
          if (sb.size() == 0) flag("unexpected_done");
          else begin
            e = sb.pop_front();
            chk("done_for_err_req", e.is_err, 0);
            chk("enables_per_req", en_cnt, 1);
            chk("result", result, e.res);
            prev_done = 1'b1;
            en_cnt    = 0;
          end
        end
      end
    end
  end

  task automatic issue(input int unsigned av, bv, mv, input bit poke);
    ent_t e;
    @(posedge clk);
    #1;
    start_p  = 1'b1;
    a        = NB'(av);
    b        = NB'(bv);
    m        = NB'(mv);
    m_size   = 4'd8;
    e.is_err = (mv % 2) == 0;
    e.a      = av;
    e.b      = bv;
    e.m      = mv;
    e.t      = cyc + 1;
    e.lat    = 2 * ML;
    e.res    = 0;
    if (!e.is_err) begin
      e.res = golden(av, bv, mv);
`ifdef MONT_TABLE_CACHE_EN
      if (cv && bv == cb && mv == cm) e.lat = 1;
      cv = 1'b1;
      cb = bv;
      cm = mv;
`endif
      last_m = mv;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    start_p = 1'b0;
    a = NB'($urandom);
    b = NB'($urandom);
    m = NB'($urandom) | 8'd1;
    if (poke) begin
      // Stray start and core-done while tables are being built.
      @(posedge clk);
      #1;
      start_p    = 1'b1;
      stray_done = 1'b1;
      @(posedge clk);
      #1;
      start_p    = 1'b0;
      stray_done = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (sb.size() != 0) begin
      flag("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic wait_en();
    int g;
    g = 0;
    while (en_cnt == 0 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (en_cnt == 0) flag("enable_timeout");
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done_p, 0);
    chk({tag, "_err"}, err_p, 0);
    chk({tag, "_enable"}, mul_enable_p, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_m"}, mul_m, 0);
    chk({tag, "_mul_m_size"}, mul_m_size, 0);
    for (int j = 1; j < ML; j++) chk($sformatf("%s_bxn%0d", tag, j), mul_bxn[j], 0);
    for (int r = 0; r < ML; r++) chk($sformatf("%s_mxn%0d", tag, r), mul_mxn[r], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned av, bv, mv, pb, pm;
    int          sel;
    rst_n      = 1'b0;
    start_p    = 1'b0;
    a          = '0;
    b          = '0;
    m          = '0;
    m_size     = '0;
    stray_done = 1'b0;
    pb         = 7;
    pm         = 13;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_checks("init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(5, 7, 13, 1'b0);   wait_drain();
    issue(11, 7, 13, 1'b0);  wait_drain();
    issue(3, 9, 13, 1'b0);   wait_drain();
    issue(4, 9, 12, 1'b0);   wait_drain();
    issue(6, 9, 13, 1'b0);   wait_drain();

    // Ignored start during table build and during WAIT.
    issue(8, 2, 13, 1'b1);
    wait_en();
    @(posedge clk);
    #1;
    start_p = 1'b1;
    @(posedge clk);
    #1;
    start_p = 1'b0;
    wait_drain();

    // Core done pulse while idle.
    @(posedge clk);
    #1;
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    repeat (5) @(posedge clk);

    // Reset while waiting on the core, then a late core done.
    mul_hold = 1'b1;
    issue(7, 5, 11, 1'b0);
    wait_en();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    last_m = 0;
`ifdef MONT_TABLE_CACHE_EN
    cv = 1'b0;
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_checks("midrst");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    mul_hold   = 1'b0;
    repeat (8) @(posedge clk);
    issue(7, 5, 11, 1'b0);   wait_drain();

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        mv = 2 * $urandom_range(1, 127);
        bv = $urandom_range(0, 255);
      end else if (sel < 4) begin
        mv = pm;
        bv = pb;
      end else begin
        mv = 2 * $urandom_range(1, 127) + 1;
        bv = $urandom_range(0, mv - 1);
      end
      av = $urandom_range(0, (mv > 1) ? mv - 1 : 0);
      if ((mv % 2) == 1) begin
        pb = bv;
        pm = mv;
      end
      issue(av, bv, mv, 1'b0);
      wait_drain();
    end

    repeat (10) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
